// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver shared types, scan-code constants and parity helper
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
    localparam logic [7:0] PS2_KEY_UP    = 8'h75;
    localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;

    // PS/2 uses odd parity across the data byte plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - two-flop synchronizers plus ps2_clk glitch filter and falling-edge pulse
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          clk_filt;
    logic [FW-1:0] run_cnt;

    // Lines idle high, so synchronizers and filter come out of reset at 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_filt  <= 1'b1;
            run_cnt   <= '0;
            clk_fall  <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            clk_fall  <= 1'b0;
            if (clk_sync != clk_filt) begin
                if (run_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_sync;
                    run_cnt  <= '0;
                    clk_fall <= clk_filt;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard frame receiver with E0/F0 prefix decode; parity check under PS2_PARITY_CHECK_EN
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboardCode,
    output logic       ps2_ready,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_t    state;
    ps2_state_t    state_nxt;
    logic          sample;
    logic          bit_in;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic [TW-1:0] idle_cnt;
    logic          ext_flag;
    logic          brk_flag;
    logic          timeout_hit;
    logic          parity_ok;
    logic          frame_good;
    logic          frame_bad;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (sample),
        .data_sync (bit_in)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (sample && state == PARITY) begin
            par_q <= bit_in;
        end
    end

    assign parity_ok = odd_parity_ok(shift_q, par_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign timeout_hit = (state != IDLE) && !sample && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (timeout_hit) begin
            state_nxt = IDLE;
            frame_bad = 1'b1;
        end else if (sample) begin
            case (state)
                IDLE: begin
                    if (!bit_in) state_nxt = DATA;
                    else         frame_bad = 1'b1;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (bit_in && parity_ok) frame_good = 1'b1;
                    else                     frame_bad  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt      <= 3'd0;
            shift_q      <= 8'h00;
            idle_cnt     <= '0;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            keyboardCode <= 8'h00;
            ps2_ready    <= 1'b0;
            key_break    <= 1'b0;
            key_ext      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            ps2_ready <= 1'b0;
            frame_err <= frame_bad;

            if (state == IDLE || sample) idle_cnt <= '0;
            else                         idle_cnt <= idle_cnt + 1'b1;

            if (sample && state == IDLE) bit_cnt <= 3'd0;
            if (sample && state == DATA) begin
                shift_q <= {bit_in, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (timeout_hit) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end

            // Prefix bytes only arm flags; the next real code consumes them.
            if (frame_good) begin
                if (shift_q == PS2_EXT_PREFIX) begin
                    ext_flag <= 1'b1;
                end else if (shift_q == PS2_BREAK_PREFIX) begin
                    brk_flag <= 1'b1;
                end else begin
                    keyboardCode <= shift_q;
                    key_break    <= brk_flag;
                    key_ext      <= ext_flag;
                    ps2_ready    <= 1'b1;
                    ext_flag     <= 1'b0;
                    brk_flag     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb/tb_ps2_key_receiver.sv - directed-vector bench for ps2_key_receiver
module tb_ps2_key_receiver;

    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyboardCode;
    logic       ps2_ready;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;

    int   n_vec = 0;
    int   n_miss = 0;
    int   rdy_cnt = 0;
    int   err_cnt = 0;
    int   wide_cnt = 0;
    logic rdy_prev = 1'b0;

    always #5 clk = ~clk;

    ps2_key_receiver #(.TIMEOUT_CYC(TO), .FILTER_LEN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keyboardCode (keyboardCode),
        .ps2_ready    (ps2_ready),
        .key_break    (key_break),
        .key_ext      (key_ext),
        .frame_err    (frame_err)
    );

    always @(negedge clk) begin
        if (ps2_ready) rdy_cnt++;
        if (frame_err) err_cnt++;
        if (ps2_ready && rdy_prev) wide_cnt++;
        rdy_prev = ps2_ready;
    end

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        rdy_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input int nbits, input int glitch_after);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i]);
            if (i == glitch_after) begin
                repeat (5) @(posedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(posedge clk);
                ps2_clk = 1'b1;
            end
        end
        ps2_data = 1'b1;
        repeat (3 * HALF) @(posedge clk);
    endtask

    initial begin
        logic [10:0] f;

        repeat (5) @(posedge clk);
        #1;
        check_vec("rst_code", 32'(keyboardCode), 0);
        check_vec("rst_ready", 32'(ps2_ready), 0);
        check_vec("rst_break", 32'(key_break), 0);
        check_vec("rst_ext", 32'(key_ext), 0);
        check_vec("rst_err", 32'(frame_err), 0);
        @(posedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);

        clear_counts();
        send_frame(8'h6B, 1'b0, 11, -1);
        check_vec("6b_ready_cnt", rdy_cnt, 1);
        check_vec("6b_err_cnt", err_cnt, 0);
        check_vec("6b_code", 32'(keyboardCode), 32'h6B);
        check_vec("6b_break", 32'(key_break), 0);
        check_vec("6b_ext", 32'(key_ext), 0);

        clear_counts();
        send_frame(8'hE0, 1'b0, 11, -1);
        check_vec("e0_no_ready", rdy_cnt, 0);
        check_vec("e0_code_hold", 32'(keyboardCode), 32'h6B);
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h74, 1'b0, 11, -1);
        check_vec("e0f074_ready_cnt", rdy_cnt, 1);
        check_vec("e0f074_code", 32'(keyboardCode), 32'h74);
        check_vec("e0f074_ext", 32'(key_ext), 1);
        check_vec("e0f074_break", 32'(key_break), 1);
        check_vec("e0f074_err", err_cnt, 0);

        clear_counts();
        send_frame(8'h75, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
        check_vec("badpar_err_cnt", err_cnt, 1);
        check_vec("badpar_ready_cnt", rdy_cnt, 0);
        check_vec("badpar_code_hold", 32'(keyboardCode), 32'h74);
`else
        check_vec("badpar_err_cnt", err_cnt, 0);
        check_vec("badpar_ready_cnt", rdy_cnt, 1);
        check_vec("badpar_code", 32'(keyboardCode), 32'h75);
        check_vec("badpar_break", 32'(key_break), 0);
`endif

        clear_counts();
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'h72, 1'b0, 6, -1);
        repeat (TO + 10) @(posedge clk);
        check_vec("tmo_err_cnt", err_cnt, 1);
        check_vec("tmo_ready_cnt", rdy_cnt, 0);
        send_frame(8'h72, 1'b0, 11, -1);
        check_vec("tmo_after_ready", rdy_cnt, 1);
        check_vec("tmo_after_code", 32'(keyboardCode), 32'h72);
        check_vec("tmo_ext_cleared", 32'(key_ext), 0);
        check_vec("tmo_after_err", err_cnt, 1);

        f = {1'b1, ~^8'h74, 8'h74, 1'b0};
        for (int i = 0; i < 4; i++) ps2_bit(f[i]);
        ps2_data = f[4];
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("midrst_code", 32'(keyboardCode), 0);
        check_vec("midrst_ready", 32'(ps2_ready), 0);
        check_vec("midrst_err", 32'(frame_err), 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        rst = 1'b1;
        clear_counts();
        repeat (20) @(posedge clk);
        send_frame(8'h6B, 1'b0, 11, -1);
        check_vec("midrst_ready_cnt", rdy_cnt, 1);
        check_vec("midrst_err_cnt", err_cnt, 0);
        check_vec("midrst_new_code", 32'(keyboardCode), 32'h6B);

        clear_counts();
        send_frame(8'h74, 1'b0, 11, 3);
        check_vec("glitch_ready_cnt", rdy_cnt, 1);
        check_vec("glitch_err_cnt", err_cnt, 0);
        check_vec("glitch_code", 32'(keyboardCode), 32'h74);

        check_vec("ready_width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200000, clk cycles of PS/2 clock inactivity that abort a partial frame (2 ms at 100 MHz).
REQ-002 SHALL have parameter FILTER_LEN, default 4, number of consecutive equal synchronized samples required to accept a new ps2_clk level.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 device clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 device data, asynchronous to clk.
REQ-007 SHALL have port keyboardCode  output  8  last accepted non-prefix scan code.
REQ-008 SHALL have port ps2_ready  output  1  one-clk pulse marking a new keyboardCode.
REQ-009 SHALL have port key_break  output  1  keyboardCode was preceded by 0xF0 (key release).
REQ-010 SHALL have port key_ext  output  1  keyboardCode was preceded by 0xE0 (extended key).
REQ-011 SHALL have port frame_err  output  1  one-clk pulse on start, parity, stop or timeout error.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through two flip-flops each before any use.
REQ-013 SHALL change the filtered clock level only after FILTER_LEN equal synchronized samples; a falling edge of the filtered clock is the bit-sample event.
REQ-014 SHALL sample synchronized ps2_data on each bit-sample event.
REQ-015 SHALL use FSM states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on a sample of 0 go to DATA with bit count 0; on a sample of 1 stay in IDLE and pulse frame_err.
REQ-017 DATA: shift bits LSB first; after the 8th bit go to PARITY.
REQ-018 PARITY: store the bit and go to STOP.
REQ-019 STOP: sample 1 with odd parity over 8 data bits plus parity bit -> frame valid; any other case -> frame_err pulse, frame dropped; always return to IDLE.
REQ-020 SHALL count clk cycles since the last bit-sample event while not in IDLE; on reaching TIMEOUT_CYC go to IDLE, discard the frame, clear prefix flags, and pulse frame_err.
REQ-021 Valid byte 0xE0 SHALL set the internal ext flag and produce no ps2_ready.
REQ-022 Valid byte 0xF0 SHALL set the internal break flag and produce no ps2_ready.
REQ-023 Any other valid byte SHALL update keyboardCode, key_break and key_ext, pulse ps2_ready, and clear both internal flags.
REQ-024 ps2_ready SHALL rise exactly 1 clk after the clk in which the STOP sample is taken, and SHALL last exactly 1 clk.
REQ-025 keyboardCode, key_break and key_ext SHALL hold their values until the next ps2_ready.
REQ-026 E0 followed by F0 SHALL yield both flags set on the following code; a repeated prefix SHALL keep its flag set (idempotent).

Reset
REQ-027 While rst=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, the bit count, timeout counter and prefix flags SHALL be 0, and the filtered clock SHALL be 1.
REQ-028 Reset asserted mid-frame SHALL discard the frame, with no ps2_ready or frame_err after release.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, a parity mismatch SHALL drop the frame and pulse frame_err.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored; a stop bit of 1 alone makes the frame valid.

Structure
REQ-031 Shared package ps2_pkg SHALL hold the FSM state typedef and these constants:
- prefixes: 0xE0 and 0xF0.
- arrow codes: 0x6B left, 0x74 right, 0x75 up, 0x72 down.
REQ-032 The synchronizer and filter SHALL be the sub-module ps2_sync_filter, with outputs for the filtered-clock falling-edge pulse and synchronized data.

Verification
REQ-033 Frame 0x6B, correct parity -> one ps2_ready pulse; keyboardCode=0x6B, key_break=0, key_ext=0.
REQ-034 Frames E0, F0, 74 -> exactly one ps2_ready pulse; keyboardCode=0x74, key_ext=1, key_break=1.
REQ-035 Frame 0x75 with flipped parity -> frame_err pulse and no ps2_ready when PS2_PARITY_CHECK_EN is defined; ps2_ready with 0x75 when it is not.
REQ-036 Stop after 5 data bits, idle TIMEOUT_CYC+10 cycles, then frame 0x72 -> one frame_err pulse, then ps2_ready with keyboardCode=0x72.
REQ-037 rst=0 asserted during bit 4 of a frame, then released, then frame 0x6B -> outputs 0 during reset; only the 0x6B frame produces ps2_ready.
REQ-038 A ps2_clk glitch shorter than FILTER_LEN clk cycles during frame 0x74 -> no extra bit sampled; keyboardCode=0x74.
